// File: rtl/gate_share_pkg.sv
// Shared types and helpers for the gate-sharing arbiter.
// The requester search is written for at most 16 requesters, the upper
// bound of the arbiter's N parameter.
package gate_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int STATS_W  = 16;
    localparam int MAX_N    = 16;
    localparam int MAX_ID_W = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_result_t;

    // Round-robin search: first set bit of valid starting at ptr+1, wrapping modulo n.
    function automatic rr_result_t rr_pick(
        input logic [MAX_N-1:0]    valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int                  n
    );
        rr_result_t          r;
        int                  cand;
        logic [MAX_ID_W-1:0] cand_idx;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            cand     = (int'(ptr) + k) % n;
            cand_idx = MAX_ID_W'(cand);
            if (k <= n && !r.found && valid[cand_idx]) begin
                r.found = 1'b1;
                r.idx   = cand_idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_share_arbiter_rr_picker.sv
// Combinational round-robin priority search over N request bits.
// The search begins at the requester after ptr, so the last-served
// requester has the lowest priority.
module rr_picker
    import gate_share_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            found
);

    rr_result_t pick;

    // Widen to the package search width, then narrow the chosen index back.
    always_comb begin
        pick  = rr_pick(MAX_N'(valid), MAX_ID_W'(ptr), N);
        grant = ID_W'(pick.idx);
        found = pick.found;
    end

endmodule

// File: rtl/gate_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external two-input gate among
// N requesters: grant, latch operands, hold the gate for EVAL_CYCLES,
// sample Y, then return a tagged response over valid/ready.
// Optional statistics (grant counter and busy flag) are built when the
// macro GATE_SHARE_ARB_STATS_EN is defined.
module gate_share_arbiter
    import gate_share_pkg::*;
#(
    parameter int N           = 4,
    parameter int ID_W        = $clog2(N),
    parameter int EVAL_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N-1:0]       io_req_valid,
    output logic [N-1:0]       io_req_ready,
    input  logic [N-1:0]       io_req_A,
    input  logic [N-1:0]       io_req_B,
    output logic               io_gate_A,
    output logic               io_gate_B,
    input  logic               io_gate_Y,
    output logic               io_resp_valid,
    input  logic               io_resp_ready,
    output logic [ID_W-1:0]    io_resp_id,
    output logic               io_resp_Y
`ifdef GATE_SHARE_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] io_grant_count,
    output logic               io_busy
`endif
);

    localparam int CNT_W = 4;

    state_t           state;
    state_t           next_state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  grant;
    logic             found;
    logic             op_a;
    logic             op_b;
    logic             res;
    logic [CNT_W-1:0] cnt;
    logic             resp_fire;

    rr_picker #(
        .N    (N),
        .ID_W (ID_W)
    ) u_picker (
        .valid (io_req_valid),
        .ptr   (ptr),
        .grant (grant),
        .found (found)
    );

    assign resp_fire     = (state == RESP) && io_resp_ready;
    assign io_gate_A     = op_a;
    assign io_gate_B     = op_b;
    assign io_resp_valid = (state == RESP);
    assign io_resp_id    = id;
    assign io_resp_Y     = res;

    // Next-state selection for the grant / evaluate / respond sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = EVAL;
            EVAL:    if (cnt == '0) next_state = RESP;
            RESP:    if (io_resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One-hot accept to the winner, only while idle and never during reset so a requester cannot drop a request that is not latched.
    always_comb begin
        io_req_ready = '0;
        if (state == IDLE && found && !reset) begin
            io_req_ready[grant] = 1'b1;
        end
    end

    // State, operand latch, evaluation countdown, result capture and pointer update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= ID_W'(N - 1);
            op_a  <= 1'b0;
            op_b  <= 1'b0;
            res   <= 1'b0;
            id    <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a <= io_req_A[grant];
                        op_b <= io_req_B[grant];
                        id   <= grant;
                        cnt  <= CNT_W'(EVAL_CYCLES - 1);
                    end
                end
                EVAL: begin
                    if (cnt == '0) begin
                        res <= io_gate_Y;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (io_resp_ready) begin
                        ptr <= id;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_SHARE_ARB_STATS_EN
    assign io_busy = (state != IDLE);

    // Saturating count of completed response handshakes.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_grant_count <= '0;
        end else if (resp_fire && io_grant_count != {STATS_W{1'b1}}) begin
            io_grant_count <= io_grant_count + 1'b1;
        end
    end
`else
    logic unused_fire;
    assign unused_fire = resp_fire;
`endif

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Self-checking bench for gate_share_arbiter: one instance with
// EVAL_CYCLES=1 and a combinational AND gate, one with EVAL_CYCLES=3 and
// a registered AND gate whose Y settles a cycle after its inputs.
// Statistics checks are compiled when GATE_SHARE_ARB_STATS_EN is defined.
module tb_gate_share_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            y;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [N-1:0]    req_valid0, req_ready0, req_a0, req_b0;
    logic            gate_a0, gate_b0, gate_y0, resp_valid0, resp_ready0, resp_y0;
    logic [ID_W-1:0] resp_id0;
    logic [N-1:0]    req_valid1, req_ready1, req_a1, req_b1;
    logic            gate_a1, gate_b1, gate_y1, resp_valid1, resp_ready1, resp_y1;
    logic [ID_W-1:0] resp_id1;
`ifdef GATE_SHARE_ARB_STATS_EN
    logic [15:0]     grant_count0, grant_count1;
    logic            busy0, busy1;
`endif

    exp_t sb[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    assign gate_y0 = gate_a0 & gate_b0;

    always @(posedge clock) gate_y1 <= gate_a1 & gate_b1;

    gate_share_arbiter #(.N(N), .EVAL_CYCLES(1)) dut0 (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid0), .io_req_ready(req_ready0),
        .io_req_A(req_a0), .io_req_B(req_b0),
        .io_gate_A(gate_a0), .io_gate_B(gate_b0), .io_gate_Y(gate_y0),
        .io_resp_valid(resp_valid0), .io_resp_ready(resp_ready0),
        .io_resp_id(resp_id0), .io_resp_Y(resp_y0)
`ifdef GATE_SHARE_ARB_STATS_EN
        , .io_grant_count(grant_count0), .io_busy(busy0)
`endif
    );

    gate_share_arbiter #(.N(N), .EVAL_CYCLES(3)) dut1 (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid1), .io_req_ready(req_ready1),
        .io_req_A(req_a1), .io_req_B(req_b1),
        .io_gate_A(gate_a1), .io_gate_B(gate_b1), .io_gate_Y(gate_y1),
        .io_resp_valid(resp_valid1), .io_resp_ready(resp_ready1),
        .io_resp_id(resp_id1), .io_resp_Y(resp_y1)
`ifdef GATE_SHARE_ARB_STATS_EN
        , .io_grant_count(grant_count1), .io_busy(busy1)
`endif
    );

    function automatic exp_t make_exp(input logic [ID_W-1:0] id, input logic y);
        exp_t e;
        e.id = id;
        e.y  = y;
        return e;
    endfunction

    task automatic do_reset();
        reset       = 1'b1;
        req_valid0  = '0; req_a0 = '0; req_b0 = '0; resp_ready0 = 1'b0;
        req_valid1  = '0; req_a1 = '0; req_b1 = '0; resp_ready1 = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++; if (req_ready0 !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready0); end
        checks++; if (resp_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid0); end
        checks++; if ({gate_a0, gate_b0} !== 2'b00) begin errors++; $display("[TB] FAIL reset_gate: got %b expected 00", {gate_a0, gate_b0}); end
        checks++; if (resp_id0 !== 2'd0 || resp_y0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_fields: got id=%0d y=%b expected id=0 y=0", resp_id0, resp_y0); end
    endtask

    task automatic test_single();
        do_reset();
        resp_ready0 = 1'b1;
        req_valid0 = 4'b0001; req_a0 = 4'b0001; req_b0 = 4'b0001;
        sb.push_back(make_exp(2'd0, 1'b1));
        @(negedge clock);
        checks++; if (req_ready0 !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant: got %b expected 0001", req_ready0); end
        @(posedge clock); #1 req_valid0 = '0;
        @(negedge clock);
        checks++; if (resp_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL single_eval_valid: got %b expected 0", resp_valid0); end
        checks++; if ({gate_a0, gate_b0} !== 2'b11) begin errors++; $display("[TB] FAIL single_gate_inputs: got %b expected 11", {gate_a0, gate_b0}); end
        @(negedge clock);
        checks++; if (resp_valid0 !== 1'b1) begin errors++; $display("[TB] FAIL single_resp_valid: got %b expected 1", resp_valid0); end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            checks++; if (resp_id0 !== got.id || resp_y0 !== got.y) begin errors++; $display("[TB] FAIL single_resp: got id=%0d y=%b expected id=%0d y=%b", resp_id0, resp_y0, got.id, got.y); end
        end
        @(negedge clock);
        checks++; if (resp_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL single_back_idle: got %b expected 0", resp_valid0); end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        int grants = 0;
        int resps  = 0;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        resp_ready0 = 1'b1;
        req_valid0 = 4'b1111; req_a0 = 4'b1010; req_b0 = 4'b1110;
        for (int cyc = 0; cyc < 40 && resps < 5; cyc++) begin
            @(negedge clock);
            checks++; if (!$onehot0(req_ready0)) begin errors++; $display("[TB] FAIL rr_onehot: got %b expected at most one bit", req_ready0); end
            if (req_ready0 != '0) begin
                if (grants < 5) begin
                    checks++; if (req_ready0 !== (4'b0001 << order[grants])) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b expected requester %0d", grants, req_ready0, order[grants]); end
                    sb.push_back(make_exp(order[grants], req_a0[order[grants]] & req_b0[order[grants]]));
                end
                grants++;
            end
            if (resp_valid0 && resp_ready0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("[TB] FAIL rr_unexpected_resp: got id=%0d expected no response", resp_id0);
                end else begin
                    got = sb.pop_front();
                    if (resp_id0 !== got.id || resp_y0 !== got.y) begin errors++; $display("[TB] FAIL rr_resp%0d: got id=%0d y=%b expected id=%0d y=%b", resps, resp_id0, resp_y0, got.id, got.y); end
                end
                resps++;
            end
        end
        checks++; if (resps != 5) begin errors++; $display("[TB] FAIL rr_timeout: got %0d responses expected 5", resps); end
    endtask

    task automatic test_backpressure();
        do_reset();
        resp_ready0 = 1'b0;
        req_valid0 = 4'b1111; req_a0 = 4'b1011; req_b0 = 4'b1111;
        sb.push_back(make_exp(2'd0, 1'b1));
        @(negedge clock);
        checks++; if (req_ready0 !== 4'b0001) begin errors++; $display("[TB] FAIL bp_grant: got %b expected 0001", req_ready0); end
        repeat (2) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid0 !== 1'b1 || resp_id0 !== 2'd0 || resp_y0 !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold%0d: got v=%b id=%0d y=%b expected v=1 id=0 y=1", i, resp_valid0, resp_id0, resp_y0); end
            checks++; if (req_ready0 !== 4'b0000) begin errors++; $display("[TB] FAIL bp_no_grant%0d: got %b expected 0000", i, req_ready0); end
            @(negedge clock);
        end
        resp_ready0 = 1'b1;
        #1;
        got = sb.pop_front();
        checks++; if (resp_valid0 !== 1'b1 || resp_id0 !== got.id || resp_y0 !== got.y) begin errors++; $display("[TB] FAIL bp_release: got v=%b id=%0d y=%b expected v=1 id=%0d y=%b", resp_valid0, resp_id0, resp_y0, got.id, got.y); end
        @(negedge clock);
        checks++; if (req_ready0 !== 4'b0010) begin errors++; $display("[TB] FAIL bp_next_grant: got %b expected 0010", req_ready0); end
    endtask

    task automatic test_eval_cycles();
        logic [3:0] masks [2];
        logic [3:0] as [2];
        logic [3:0] bs [2];
        logic [1:0] ids [2];
        masks = '{4'b0001, 4'b0010};
        as    = '{4'b0001, 4'b0010};
        bs    = '{4'b0001, 4'b0000};
        ids   = '{2'd0, 2'd1};
        do_reset();
        resp_ready1 = 1'b1;
        for (int t = 0; t < 2; t++) begin
            req_valid1 = masks[t]; req_a1 = as[t]; req_b1 = bs[t];
            sb.push_back(make_exp(ids[t], as[t][ids[t]] & bs[t][ids[t]]));
            @(negedge clock);
            checks++; if (req_ready1 !== masks[t]) begin errors++; $display("[TB] FAIL ev_grant%0d: got %b expected %b", t, req_ready1, masks[t]); end
            @(posedge clock); #1 req_valid1 = '0;
            for (int e = 0; e < 3; e++) begin
                @(negedge clock);
                checks++; if (gate_a1 !== as[t][ids[t]] || gate_b1 !== bs[t][ids[t]] || resp_valid1 !== 1'b0) begin errors++; $display("[TB] FAIL ev_hold%0d_%0d: got a=%b b=%b v=%b expected a=%b b=%b v=0", t, e, gate_a1, gate_b1, resp_valid1, as[t][ids[t]], bs[t][ids[t]]); end
            end
            @(negedge clock);
            got = sb.pop_front();
            checks++; if (resp_valid1 !== 1'b1 || resp_id1 !== got.id || resp_y1 !== got.y) begin errors++; $display("[TB] FAIL ev_resp%0d: got v=%b id=%0d y=%b expected v=1 id=%0d y=%b", t, resp_valid1, resp_id1, resp_y1, got.id, got.y); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid_eval();
        bit seen = 0;
        do_reset();
        resp_ready1 = 1'b1;
        req_valid1 = 4'b0001; req_a1 = 4'b0001; req_b1 = 4'b0001;
        @(negedge clock);
        checks++; if (req_ready1 !== 4'b0001) begin errors++; $display("[TB] FAIL rm_grant: got %b expected 0001", req_ready1); end
        @(posedge clock); #1 req_valid1 = '0;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        checks++; if ({gate_a1, gate_b1, resp_valid1, resp_id1, resp_y1} !== 6'b0) begin errors++; $display("[TB] FAIL rm_outputs_zero: got a=%b b=%b v=%b id=%0d y=%b expected all zero", gate_a1, gate_b1, resp_valid1, resp_id1, resp_y1); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checks++; if (resp_valid1 !== 1'b0) begin errors++; $display("[TB] FAIL rm_dropped%0d: got resp_valid=%b expected 0", i, resp_valid1); end
        end
        @(posedge clock); #1;
        req_valid1 = 4'b0100; req_a1 = 4'b0100; req_b1 = 4'b0100;
        sb.push_back(make_exp(2'd2, 1'b1));
        @(negedge clock);
        checks++; if (req_ready1 !== 4'b0100) begin errors++; $display("[TB] FAIL rm_regrant: got %b expected 0100", req_ready1); end
        @(posedge clock); #1 req_valid1 = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (resp_valid1) begin
                seen = 1;
                got = sb.pop_front();
                checks++; if (resp_id1 !== got.id || resp_y1 !== got.y) begin errors++; $display("[TB] FAIL rm_resp: got id=%0d y=%b expected id=%0d y=%b", resp_id1, resp_y1, got.id, got.y); end
            end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL rm_timeout: got no response expected one within 10 cycles"); end
    endtask

`ifdef GATE_SHARE_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        @(negedge clock);
        checks++; if (grant_count0 !== 16'd0 || busy0 !== 1'b0) begin errors++; $display("[TB] FAIL st_reset: got cnt=%0d busy=%b expected cnt=0 busy=0", grant_count0, busy0); end
        @(posedge clock); #1;
        resp_ready0 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            req_valid0 = 4'b0001; req_a0 = 4'b0001; req_b0 = 4'b0001;
            @(negedge clock);
            checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL st_busy_grant%0d: got %b expected 0", t, busy0); end
            @(posedge clock); #1 req_valid0 = '0;
            @(negedge clock);
            checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL st_busy_eval%0d: got %b expected 1", t, busy0); end
            @(negedge clock);
            checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL st_busy_resp%0d: got %b expected 1", t, busy0); end
            @(negedge clock);
            checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL st_busy_idle%0d: got %b expected 0", t, busy0); end
            @(posedge clock); #1;
        end
        @(negedge clock);
        checks++; if (grant_count0 !== 16'd3) begin errors++; $display("[TB] FAIL st_count: got %0d expected 3", grant_count0); end
    endtask
`endif

    // Watchdog so the run always ends even if a wait never resolves.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_eval_cycles();
        test_reset_mid_eval();
`ifdef GATE_SHARE_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_share_arbiter.md
Name: gate_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external two-input gate instance (A, B -> Y black box) among N requesters.
- Grants one requester at a time, latches its operands, drives the shared gate for EVAL_CYCLES cycles, samples Y, then returns a tagged response over a valid/ready handshake.
- Sits between requester logic and the single gate wrapper, so the design never instantiates more than one gate.

Parameters:
- N, 4, number of requesters (2..16).
- ID_W, $clog2(N), width of the response requester-id field.
- EVAL_CYCLES, 1, cycles the gate inputs are held before Y is sampled (1..15).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- io_req_valid  input  N  per-requester request valid.
- io_req_ready  output  N  per-requester grant/accept, at most one bit high.
- io_req_A  input  N  per-requester operand A.
- io_req_B  input  N  per-requester operand B.
- io_gate_A  output  1  operand A to the shared gate.
- io_gate_B  output  1  operand B to the shared gate.
- io_gate_Y  input  1  result from the shared gate.
- io_resp_valid  output  1  response valid.
- io_resp_ready  input  1  response consumer ready.
- io_resp_id  output  ID_W  index of the served requester.
- io_resp_Y  output  1  sampled gate result.

Behaviour:
- Reset (synchronous, active-high, wins over all other activity, including mid-EVAL or mid-RESP):
  - state = IDLE, ptr = N-1, op_a = op_b = 0, res = 0, id = 0, cnt = 0.
  - Outputs after reset: io_req_ready = 0, io_resp_valid = 0, io_gate_A = io_gate_B = 0, io_resp_id = 0, io_resp_Y = 0.
  - Any in-flight transaction is dropped without a response.
- IDLE:
  - If io_req_valid != 0, grant = first set bit searching ptr+1, ptr+2, ... modulo N.
  - io_req_ready[grant] = 1, combinational from io_req_valid, this cycle only.
  - On the clock edge: op_a <= io_req_A[grant], op_b <= io_req_B[grant], id <= grant, cnt <= EVAL_CYCLES-1, state <= EVAL.
  - If no valid bits are set, stay in IDLE with io_req_ready = 0.
- EVAL:
  - io_gate_A/io_gate_B are driven from op_a/op_b registers in every state, so they are stable for the whole evaluation.
  - If cnt == 0: res <= io_gate_Y, state <= RESP. Otherwise cnt <= cnt-1.
  - EVAL lasts exactly EVAL_CYCLES cycles.
- RESP:
  - io_resp_valid = 1; io_resp_id = id and io_resp_Y = res, held stable until accepted.
  - On io_resp_valid & io_resp_ready: ptr <= id, state <= IDLE.
  - io_resp_valid is low in IDLE and EVAL.
- Throughput and latency:
  - Best case is one transaction per EVAL_CYCLES+2 cycles (IDLE grant, EVAL, RESP).
  - With EVAL_CYCLES=1, latency from the grant cycle to io_resp_valid is 2 cycles.
- Requester rules:
  - Requesters hold valid and operands until they see ready.
  - Deasserting valid before grant is legal and leaves no effect.
  - io_req_ready is never high outside IDLE.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,...,N-1,0 (ptr wrap-around N-1 -> 0).
- Backpressure: io_resp_ready held low stalls in RESP indefinitely; no new grants are issued during the stall.

Optional Feature:
- Macro GATE_SHARE_ARB_STATS_EN.
- When defined:
  - Adds output io_grant_count (16 bits): a saturating count of completed response handshakes.
  - Cleared by reset; sticks at 0xFFFF.
  - Adds output io_busy (1 bit) = (state != IDLE).
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package gate_share_pkg holds:
  - state enum (IDLE=2'd0, EVAL=2'd1, RESP=2'd2);
  - STATS_W = 16;
  - function rr_pick(valid, ptr) returning grant index plus a found flag.
- One sub-module, rr_picker: purely combinational N-bit round-robin priority search from ptr+1.
- FSM, operand/result registers and counters live in gate_share_arbiter.

Test Plan:
- Reset then single request: req_valid=0001, A=1, B=1, gate model is AND -> ready[0] in cycle 0; resp_valid in cycle 2 with id=0, Y=1; with resp_ready=1, back to IDLE in cycle 3.
- All four valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0; each resp_id matches; io_req_ready is never multi-hot.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp_valid, id and Y stable throughout; req_ready stays 0000; release -> next grant follows.
- EVAL_CYCLES=3, A=1, B=0, gate model changes Y only after the inputs settle -> io_gate_A=1 and io_gate_B=0 for 3 cycles; res sampled at the last EVAL cycle; Y=0.
- Reset asserted while in EVAL -> next cycle state is IDLE, outputs are zero, no response is emitted; a subsequent request with valid=0100 is granted to requester 2.
- With GATE_SHARE_ARB_STATS_EN: 3 completed handshakes -> io_grant_count=3; io_busy high exactly in the EVAL and RESP cycles.
